// File: rtl/reset_sequencer.sv
// Power-on / button reset sequencer: holds the PLL in reset, waits for a stable lock,
// then releases the peripherals and finally the core, re-sequencing on lock loss or button press.
module reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 1000000,
  parameter int unsigned LOCK_STABLE    = 4194303,
  parameter int unsigned PERIPH_GAP     = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       btn_reset_n,
  input  logic       terminate,
  output logic       pll_reset,
  output logic       periph_reset,
  output logic       core_reset,
  output logic [2:0] state
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD  = (LOCK_STABLE > PERIPH_GAP) ? LOCK_STABLE : PERIPH_GAP;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(PERIPH_GAP - 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    PERIPH    = 3'd3,
    RUN       = 3'd4,
    HALT      = 3'd5
  } state_t;

  logic          r_lock_meta;
  logic          r_lock_s;
  logic          r_btn_meta;
  logic          r_btn_s;
  state_t        r_state;
  logic [CW-1:0] r_count;
  state_t        w_next;
  logic          w_clr;

  // Two-flop synchronizers for the asynchronous lock and button pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_btn_meta  <= 1'b1;
      r_btn_s     <= 1'b1;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
      r_btn_meta  <= btn_reset_n;
      r_btn_s     <= r_btn_meta;
    end
  end

  // Next-state decode; button outranks lock loss, which outranks count expiry and terminate.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    if ((r_state != PLL_RST) && !r_btn_s) begin
      w_next = WAIT_LOCK;
    end else begin
      case (r_state)
        PLL_RST: begin
          if (r_count == PLL_LAST) w_next = WAIT_LOCK;
          else                     w_next = PLL_RST;
        end
        WAIT_LOCK: begin
          if (r_lock_s)                     w_next = STABLE;
          else if (r_count == TIMEOUT_LAST) w_next = PLL_RST;
          else                              w_next = WAIT_LOCK;
        end
        STABLE: begin
          if (!r_lock_s)                   w_next = WAIT_LOCK;
          else if (r_count == STABLE_LAST) w_next = PERIPH;
          else                             w_next = STABLE;
        end
        PERIPH: begin
          if (!r_lock_s)                w_next = WAIT_LOCK;
          else if (r_count == GAP_LAST) w_next = RUN;
          else                          w_next = PERIPH;
        end
        RUN: begin
          if (!r_lock_s)      w_next = WAIT_LOCK;
          else if (terminate) w_next = HALT;
          else                w_next = RUN;
        end
        HALT: begin
          if (!r_lock_s) w_next = WAIT_LOCK;
          else           w_next = HALT;
        end
        default: w_next = PLL_RST;
      endcase
    end
    // A held button pins the counter at zero so WAIT_LOCK cannot time out.
    if ((w_next != r_state) || ((w_next == WAIT_LOCK) && !r_btn_s)) begin
      w_clr = 1'b1;
    end else begin
      w_clr = 1'b0;
    end
  end

  // State, shared counter and next-state-decoded registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= PLL_RST;
      r_count      <= '0;
      pll_reset    <= 1'b1;
      periph_reset <= 1'b1;
      core_reset   <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_clr) begin
        r_count <= '0;
      end else if (r_count != CNT_MAX) begin
        r_count <= r_count + CW'(1);
      end else begin
        r_count <= r_count;
      end
      pll_reset    <= (w_next == PLL_RST);
      periph_reset <= !((w_next == PERIPH) || (w_next == RUN) || (w_next == HALT));
      core_reset   <= (w_next != RUN);
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short parameters; expected values are hand-derived
// from edge counts after each stimulus change (inputs change and outputs are sampled 1 ns after a rising edge).
module tb_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       pll_lock;
  logic       btn_reset_n;
  logic       terminate;
  logic       pll_reset;
  logic       periph_reset;
  logic       core_reset;
  logic [2:0] state;

  int n_vec  = 0;
  int n_miss = 0;

  reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (100),
    .LOCK_STABLE   (16),
    .PERIPH_GAP    (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .btn_reset_n (btn_reset_n),
    .terminate   (terminate),
    .pll_reset   (pll_reset),
    .periph_reset(periph_reset),
    .core_reset  (core_reset),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic pr, input logic per, input logic cr);
    check({tag, ".state"}, state, st);
    check({tag, ".pll_reset"}, {2'b00, pll_reset}, {2'b00, pr});
    check({tag, ".periph_reset"}, {2'b00, periph_reset}, {2'b00, per});
    check({tag, ".core_reset"}, {2'b00, core_reset}, {2'b00, cr});
  endtask

  initial begin
    reset = 1'b0; pll_lock = 1'b0; btn_reset_n = 1'b1; terminate = 1'b0;
    tick(2);
    check_outs("por", 3'd0, 1'b1, 1'b1, 1'b1);

    // Power-up: PLL_RST spans the first four edges after release.
    reset = 1'b1;
    tick(3);  check_outs("pll_hold", 3'd0, 1'b1, 1'b1, 1'b1);
    tick(1);  check_outs("wait_entry", 3'd1, 1'b0, 1'b1, 1'b1);
    tick(5);  check("wait_idle", state, 3'd1);
    pll_lock = 1'b1;
    tick(2);  check("sync_lag", state, 3'd1);
    tick(1);  check("stable_entry", state, 3'd2);
    tick(15); check_outs("stable_end", 3'd2, 1'b0, 1'b1, 1'b1);
    tick(1);  check_outs("periph_entry", 3'd3, 1'b0, 1'b0, 1'b1);
    tick(7);  check_outs("periph_end", 3'd3, 1'b0, 1'b0, 1'b1);
    tick(1);  check_outs("run_entry", 3'd4, 1'b0, 1'b0, 1'b0);

    // Halt, repeated terminate, then button press and full re-release.
    terminate = 1'b1;
    tick(1);  check_outs("halt", 3'd5, 1'b0, 1'b0, 1'b1);
    terminate = 1'b0;
    tick(2);  check("halt_stay", state, 3'd5);
    terminate = 1'b1;
    tick(1);  check_outs("halt_term2", 3'd5, 1'b0, 1'b0, 1'b1);
    terminate = 1'b0;
    btn_reset_n = 1'b0;
    tick(2);  check("btn_lag", state, 3'd5);
    tick(1);  check_outs("btn_wait", 3'd1, 1'b0, 1'b1, 1'b1);
    tick(150); check_outs("btn_hold_no_timeout", 3'd1, 1'b0, 1'b1, 1'b1);
    btn_reset_n = 1'b1;
    tick(2);  check("btn_release_lag", state, 3'd1);
    tick(1);  check("btn_stable", state, 3'd2);
    tick(15); check("btn_stable_end", state, 3'd2);
    tick(1);  check_outs("btn_periph", 3'd3, 1'b0, 1'b0, 1'b1);
    tick(7);  check("btn_periph_end", state, 3'd3);
    tick(1);  check_outs("btn_run", 3'd4, 1'b0, 1'b0, 1'b0);

    // Lock loss in RUN, then a one-cycle glitch at STABLE count 10 restarts the count.
    pll_lock = 1'b0;
    tick(2);  check("loss_lag", state, 3'd4);
    tick(1);  check_outs("loss_wait", 3'd1, 1'b0, 1'b1, 1'b1);
    pll_lock = 1'b1;
    tick(3);  check("relock_stable", state, 3'd2);
    tick(8);
    pll_lock = 1'b0;
    tick(1);  check("glitch_in_stable", state, 3'd2);
    pll_lock = 1'b1;
    tick(2);  check_outs("glitch_wait", 3'd1, 1'b0, 1'b1, 1'b1);
    tick(1);  check("glitch_restable", state, 3'd2);
    tick(15); check_outs("glitch_full_count", 3'd2, 1'b0, 1'b1, 1'b1);
    tick(1);  check_outs("glitch_periph", 3'd3, 1'b0, 1'b0, 1'b1);
    tick(7);  check("glitch_periph_end", state, 3'd3);
    tick(1);  check_outs("glitch_run", 3'd4, 1'b0, 1'b0, 1'b0);

    // Button, lock loss and terminate on the same edge: button wins.
    btn_reset_n = 1'b0; pll_lock = 1'b0;
    tick(2);  check("simul_lag", state, 3'd4);
    terminate = 1'b1;
    tick(1);  check_outs("simul", 3'd1, 1'b0, 1'b1, 1'b1);
    terminate = 1'b0; btn_reset_n = 1'b1; pll_lock = 1'b1;
    tick(2);  check("simul_recover_lag", state, 3'd1);
    tick(1);  check("simul_stable", state, 3'd2);
    tick(16); check_outs("pre_reset_periph", 3'd3, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in PERIPH, then PLL timeout loop with lock held low.
    pll_lock = 1'b0;
    #2 reset = 1'b0;
    #1 check_outs("async_reset", 3'd0, 1'b1, 1'b1, 1'b1);
    #1 reset = 1'b1;
    tick(3);  check_outs("restart_pll", 3'd0, 1'b1, 1'b1, 1'b1);
    tick(1);  check_outs("restart_wait", 3'd1, 1'b0, 1'b1, 1'b1);
    tick(99); check("timeout_edge", state, 3'd1);
    tick(1);  check_outs("timeout_pll", 3'd0, 1'b1, 1'b1, 1'b1);
    tick(3);  check("timeout_pll_hold", state, 3'd0);
    tick(1);  check_outs("timeout_wait2", 3'd1, 1'b0, 1'b1, 1'b1);
    tick(99); check("timeout2_edge", state, 3'd1);
    tick(1);  check_outs("timeout2_pll", 3'd0, 1'b1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
